// File: rtl/handshake_dispatcher.sv
// handshake_dispatcher
// Buffers producer words in a small circular FIFO and hands each word to one
// of two peripherals over independent 4-phase send/ack handshakes. Idle
// channels are served round-robin. Each ack arrives from a foreign clock
// domain and is passed through a 2-flop synchroniser before use.
//
// Channel FSM states (one instance per channel):
//   state  | meaning
//   IDLE   | no word held, outsend=0, may be assigned the FIFO head
//   REQ    | outsend=1, outdata held, waiting for synchronised ack high
//   REL    | outsend=0, waiting for synchronised ack low; completion on exit
module handshake_dispatcher #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clkCPU,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ack1,
    input  logic              ack2,
    output logic              outsend1,
    output logic              outsend2,
    output logic [DATA_W-1:0] outdata1,
    output logic [DATA_W-1:0] outdata2,
    output logic              busy1,
    output logic              busy2,
    output logic [CNT_W-1:0]  done_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } ch_state_t;

    // ack synchronisers
    logic r_ack1_meta, r_ack1_sync;
    logic r_ack2_meta, r_ack2_sync;

    // FIFO storage and pointers (index bits plus a wrap bit)
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;

    // channel state, data and round-robin pointer (0 = channel 1 next)
    ch_state_t         r_st1, r_st2;
    ch_state_t         w_st1_nxt, w_st2_nxt;
    logic [DATA_W-1:0] r_outdata1, r_outdata2;
    logic              r_rr_ch2;
    logic [CNT_W-1:0]  r_done_count;

    logic              w_empty, w_full;
    logic              w_push, w_pop;
    logic              w_idle1, w_idle2;
    logic              w_assign1, w_assign2;
    logic              w_done1, w_done2;
    logic [1:0]        w_inc;
    logic [DATA_W-1:0] w_head;

    // Two-flop synchronisers on each ack pin
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_ack1_meta <= 1'b0;
            r_ack1_sync <= 1'b0;
            r_ack2_meta <= 1'b0;
            r_ack2_sync <= 1'b0;
        end else begin
            r_ack1_meta <= ack1;
            r_ack1_sync <= r_ack1_meta;
            r_ack2_meta <= ack2;
            r_ack2_sync <= r_ack2_meta;
        end
    end

    // FIFO status: equal pointers are empty, equal index with differing wrap is full
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // A full FIFO refuses a push even if a pop happens on the same edge
    assign w_push  = in_valid && !w_full;

    assign w_idle1 = (r_st1 == S_IDLE);
    assign w_idle2 = (r_st2 == S_IDLE);
    assign w_pop   = !w_empty && (w_idle1 || w_idle2);

    // Channel 1 wins when it is the only idle one, or both are idle and rr names it
    assign w_assign1 = w_pop && w_idle1 && (!w_idle2 || !r_rr_ch2);
    assign w_assign2 = w_pop && !w_assign1;

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clkCPU) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointer update
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Round-robin pointer moves to the channel not just served
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_rr_ch2 <= 1'b0;
        end else if (w_assign1) begin
            r_rr_ch2 <= 1'b1;
        end else if (w_assign2) begin
            r_rr_ch2 <= 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_st1 <= S_IDLE;
            r_st2 <= S_IDLE;
        end else begin
            r_st1 <= w_st1_nxt;
            r_st2 <= w_st2_nxt;
        end
    end

    // Channel next-state logic; a synchronised ack seen in IDLE is ignored
    always_comb begin
        w_st1_nxt = r_st1;
        w_st2_nxt = r_st2;
        case (r_st1)
            S_IDLE:  if (w_assign1)    w_st1_nxt = S_REQ;
            S_REQ:   if (r_ack1_sync)  w_st1_nxt = S_REL;
            S_REL:   if (!r_ack1_sync) w_st1_nxt = S_IDLE;
            default: w_st1_nxt = S_IDLE;
        endcase
        case (r_st2)
            S_IDLE:  if (w_assign2)    w_st2_nxt = S_REQ;
            S_REQ:   if (r_ack2_sync)  w_st2_nxt = S_REL;
            S_REL:   if (!r_ack2_sync) w_st2_nxt = S_IDLE;
            default: w_st2_nxt = S_IDLE;
        endcase
    end

    // Output data loaded on assignment and held until the next one
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_outdata1 <= '0;
            r_outdata2 <= '0;
        end else begin
            if (w_assign1) begin
                r_outdata1 <= w_head;
            end
            if (w_assign2) begin
                r_outdata2 <= w_head;
            end
        end
    end

    assign w_done1 = (r_st1 == S_REL) && !r_ack1_sync;
    assign w_done2 = (r_st2 == S_REL) && !r_ack2_sync;
    assign w_inc   = {1'b0, w_done1} + {1'b0, w_done2};

    // Completion counter, both channels may finish on the same edge; wraps freely
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            r_done_count <= '0;
        end else begin
            r_done_count <= r_done_count + CNT_W'(w_inc);
        end
    end

    assign in_ready   = !w_full;
    assign outsend1   = (r_st1 == S_REQ);
    assign outsend2   = (r_st2 == S_REQ);
    assign busy1      = !w_idle1;
    assign busy2      = !w_idle2;
    assign outdata1   = r_outdata1;
    assign outdata2   = r_outdata2;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_handshake_dispatcher.sv
// Testbench for handshake_dispatcher: peripheral models on their own clocks,
// a CPU-side dispatch monitor, and a queue-based reference of accepted words.
`timescale 1ns/1ps
module tb_handshake_dispatcher;

    logic        clkCPU = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        ack1, ack2;
    logic        outsend1, outsend2;
    logic [15:0] outdata1, outdata2;
    logic        busy1, busy2;
    logic [15:0] done_count;

    int n_pass = 0;
    int n_total = 0;

    // peripheral control
    int   p_half1 = 9;
    int   p_half2 = 9;
    int   maxdly = 0;
    logic pclk1 = 1'b0, pclk2 = 1'b0;
    logic p_auto1 = 1'b0, p_auto2 = 1'b0;
    logic a1_auto = 1'b0, a2_auto = 1'b0;
    logic a1_man = 1'b0, a2_man = 1'b0;
    logic [15:0] d1, d2;
    int   comp1 = 0, comp2 = 0;
    int   stab_fail1 = 0, stab_fail2 = 0;

    // reference / observation
    logic [15:0] acc_q[$];
    logic [15:0] disp_d[$];
    int          disp_ch[$];
    logic        prev1 = 1'b0, prev2 = 1'b0;
    logic [15:0] exp_done = '0;

    assign ack1 = p_auto1 ? a1_auto : a1_man;
    assign ack2 = p_auto2 ? a2_auto : a2_man;

    handshake_dispatcher #(.DATA_W(16), .DEPTH(4), .CNT_W(16)) dut (
        .clkCPU(clkCPU), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ack1(ack1), .ack2(ack2),
        .outsend1(outsend1), .outsend2(outsend2),
        .outdata1(outdata1), .outdata2(outdata2),
        .busy1(busy1), .busy2(busy2), .done_count(done_count)
    );

    always #10 clkCPU = ~clkCPU;
    always #(p_half1) pclk1 = ~pclk1;
    always #(p_half2) pclk2 = ~pclk2;

    // Peripheral 1: acks a request after a random delay, releases after send drops
    always begin
        @(posedge pclk1);
        #0.5;
        if (p_auto1 && outsend1 && !a1_auto) begin
            d1 = outdata1;
            repeat ($urandom_range(maxdly, 0)) @(posedge pclk1);
            #0.5 a1_auto = 1'b1;
        end else if (a1_auto) begin
            if (outsend1 && outdata1 !== d1) stab_fail1++;
            if (!outsend1) begin
                repeat ($urandom_range(maxdly, 0)) @(posedge pclk1);
                #0.5 a1_auto = 1'b0;
                comp1++;
            end
        end
    end

    // Peripheral 2: same protocol on its own clock
    always begin
        @(posedge pclk2);
        #0.5;
        if (p_auto2 && outsend2 && !a2_auto) begin
            d2 = outdata2;
            repeat ($urandom_range(maxdly, 0)) @(posedge pclk2);
            #0.5 a2_auto = 1'b1;
        end else if (a2_auto) begin
            if (outsend2 && outdata2 !== d2) stab_fail2++;
            if (!outsend2) begin
                repeat ($urandom_range(maxdly, 0)) @(posedge pclk2);
                #0.5 a2_auto = 1'b0;
                comp2++;
            end
        end
    end

    // Dispatch monitor: every rising outsend is one word issued to that channel
    always @(negedge clkCPU) begin
        if (outsend1 && !prev1) begin
            disp_d.push_back(outdata1);
            disp_ch.push_back(1);
        end
        if (outsend2 && !prev2) begin
            disp_d.push_back(outdata2);
            disp_ch.push_back(2);
        end
        prev1 = outsend1;
        prev2 = outsend2;
    end

    task automatic do_reset();
        @(negedge clkCPU);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clkCPU);
        rst = 1'b0;
        exp_done = '0;
    endtask

    // Offer one word until accepted (bounded), recording it in the reference queue
    task automatic push_word(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 500; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clkCPU);
                break;
            end
            @(negedge clkCPU);
        end
        in_valid = 1'b0;
        n_total++;
        if (!ok) $display("FAIL push_timeout: word %h not accepted, required acceptance", d);
        else begin
            n_pass++;
            acc_q.push_back(d);
        end
    endtask

    // Wait until n words were dispatched since base and both channels are idle
    task automatic wait_drain(input int base, input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clkCPU);
            if (disp_d.size() - base >= n && !busy1 && !busy2 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clkCPU);
        n_total++;
        if (!ok) $display("FAIL drain_timeout: dispatched %0d, required %0d", disp_d.size() - base, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        p_auto1 = 1'b0; p_auto2 = 1'b0; a1_man = 1'b0; a2_man = 1'b0;
        do_reset();
        @(negedge clkCPU);
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if ({outsend1, outsend2, busy1, busy2} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {outsend1, outsend2, busy1, busy2}); else n_pass++;
        n_total++; if ({outdata1, outdata2} !== 32'h0) $display("FAIL rst_data: got %h want 0", {outdata1, outdata2}); else n_pass++;
        n_total++; if (done_count !== 16'h0) $display("FAIL rst_done: got %h want 0", done_count); else n_pass++;
        // bring channel 1 into REQ, then reset mid-handshake
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clkCPU);
        in_valid = 1'b0;
        @(negedge clkCPU);
        n_total++; if ({outsend1, busy1} !== 2'b11) $display("FAIL pre_rst_req: got %b want 11", {outsend1, busy1}); else n_pass++;
        rst = 1'b1;
        repeat (3) @(negedge clkCPU);
        rst = 1'b0;
        @(negedge clkCPU);
        n_total++; if ({outsend1, busy1} !== 2'b00) $display("FAIL midreq_rst_ch1: got %b want 00", {outsend1, busy1}); else n_pass++;
        n_total++; if (done_count !== 16'h0) $display("FAIL midreq_rst_done: got %h want 0", done_count); else n_pass++;
        n_total++; if (in_ready !== 1'b1 || outdata1 !== 16'h0) $display("FAIL midreq_rst_fifo: in_ready %b outdata1 %h want 1 0000", in_ready, outdata1); else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 16'hA5A5;
        @(negedge clkCPU);
        in_valid = 1'b0;
        n_total++; if (outsend1 !== 1'b0) $display("FAIL single_no_bypass: got %b want 0", outsend1); else n_pass++;
        @(negedge clkCPU);
        n_total++; if (outsend1 !== 1'b1 || outsend2 !== 1'b0) $display("FAIL single_send: got %b%b want 10", outsend1, outsend2); else n_pass++;
        n_total++; if (outdata1 !== 16'hA5A5) $display("FAIL single_data: got %h want a5a5", outdata1); else n_pass++;
        repeat (2) @(negedge clkCPU);
        a1_man = 1'b1;
        repeat (2) @(negedge clkCPU);
        n_total++; if (outsend1 !== 1'b1) $display("FAIL single_ack_a1: got %b want 1", outsend1); else n_pass++;
        @(negedge clkCPU);
        n_total++; if (outsend1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL single_ack_a2: send %b busy %b want 0 1", outsend1, busy1); else n_pass++;
        repeat (2) @(negedge clkCPU);
        a1_man = 1'b0;
        repeat (2) @(negedge clkCPU);
        n_total++; if (done_count !== 16'd0) $display("FAIL single_done_early: got %0d want 0", done_count); else n_pass++;
        @(negedge clkCPU);
        n_total++; if (done_count !== 16'd1 || busy1 !== 1'b0) $display("FAIL single_done: got %0d busy %b want 1 0", done_count, busy1); else n_pass++;
        exp_done = 16'd1;
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        maxdly = 0; p_half1 = 9; p_half2 = 9;
        p_auto1 = 1'b1; p_auto2 = 1'b1;
        base = disp_d.size();
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        wait_drain(base, 4);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (disp_d.size() <= base + i) $display("FAIL rr_missing_%0d: got none want %0d", i, i + 1);
            else if (disp_d[base+i] !== 16'(i + 1) || disp_ch[base+i] != (i % 2) + 1)
                $display("FAIL rr_word_%0d: got %h on ch%0d want %h on ch%0d", i, disp_d[base+i], disp_ch[base+i], i + 1, (i % 2) + 1);
            else n_pass++;
        end
        exp_done = exp_done + 16'd4;
        n_total++; if (done_count !== exp_done) $display("FAIL rr_done: got %0d want %0d", done_count, exp_done); else n_pass++;
    endtask

    task automatic test_full_fifo();
        int base, abase, nacc;
        logic [15:0] w [7];
        do_reset();
        p_auto1 = 1'b0; p_auto2 = 1'b0; a1_man = 1'b0; a2_man = 1'b0;
        base = disp_d.size();
        abase = acc_q.size();
        nacc = 0;
        for (int k = 0; k < 7; k++) w[k] = 16'($urandom);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = w[k];
            if (in_ready) begin
                acc_q.push_back(w[k]);
                nacc++;
            end
            @(negedge clkCPU);
        end
        in_valid = 1'b0;
        n_total++; if (nacc != 6) $display("FAIL full_accepted: got %0d want 6", nacc); else n_pass++;
        repeat (3) @(negedge clkCPU);
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if ({busy1, busy2, outsend1, outsend2} !== 4'b1111) $display("FAIL full_inflight: got %b want 1111", {busy1, busy2, outsend1, outsend2}); else n_pass++;
        n_total++; if (outdata1 !== w[0] || outdata2 !== w[1]) $display("FAIL full_heads: got %h %h want %h %h", outdata1, outdata2, w[0], w[1]); else n_pass++;
        maxdly = 2;
        p_auto1 = 1'b1; p_auto2 = 1'b1;
        wait_drain(base, 6);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (disp_d.size() <= base + i || acc_q.size() <= abase + i) $display("FAIL full_missing_%0d: got none want word", i);
            else if (disp_d[base+i] !== acc_q[abase+i]) $display("FAIL full_order_%0d: got %h want %h", i, disp_d[base+i], acc_q[abase+i]);
            else n_pass++;
        end
        exp_done = exp_done + 16'd6;
        n_total++; if (done_count !== exp_done) $display("FAIL full_done: got %0d want %0d", done_count, exp_done); else n_pass++;
    endtask

    task automatic test_async();
        int base, abase, c0;
        p_half1 = 17; p_half2 = 8; maxdly = 3;
        p_auto1 = 1'b1; p_auto2 = 1'b1;
        repeat (5) @(negedge clkCPU);
        base = disp_d.size();
        abase = acc_q.size();
        c0 = comp1 + comp2;
        for (int i = 0; i < 20; i++) begin
            push_word(16'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge clkCPU);
        end
        wait_drain(base, 20);
        n_total++; if (disp_d.size() - base != 20) $display("FAIL async_count: got %0d want 20", disp_d.size() - base); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (disp_d.size() > base + i && acc_q.size() > abase + i) begin
                n_total++;
                if (disp_d[base+i] !== acc_q[abase+i]) $display("FAIL async_order_%0d: got %h want %h", i, disp_d[base+i], acc_q[abase+i]);
                else n_pass++;
            end
        end
        n_total++; if (comp1 + comp2 - c0 != 20) $display("FAIL async_handshakes: got %0d want 20", comp1 + comp2 - c0); else n_pass++;
        exp_done = exp_done + 16'd20;
        n_total++; if (done_count !== exp_done) $display("FAIL async_done: got %0d want %0d", done_count, exp_done); else n_pass++;
    endtask

    // Manual handshake on one channel, bounded waits
    task automatic hs_manual(input int ch);
        bit ok;
        ok = 1'b0;
        if (ch == 1) a1_man = 1'b1; else a2_man = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkCPU);
            if ((ch == 1 ? outsend1 : outsend2) == 1'b0) begin ok = 1'b1; break; end
        end
        if (ch == 1) a1_man = 1'b0; else a2_man = 1'b0;
        repeat (4) @(negedge clkCPU);
        n_total++;
        if (!ok || (ch == 1 ? busy1 : busy2) !== 1'b0) $display("FAIL hs_manual_ch%0d: completed %b, required completion", ch, ok);
        else n_pass++;
    endtask

    task automatic test_spurious_wrap();
        p_auto1 = 1'b0; p_auto2 = 1'b0; a1_man = 1'b0; a2_man = 1'b0;
        do_reset();
        a2_man = 1'b1;
        repeat (4) @(negedge clkCPU);
        a2_man = 1'b0;
        repeat (4) @(negedge clkCPU);
        n_total++; if ({busy2, outsend2} !== 2'b00) $display("FAIL spurious_state: got %b want 00", {busy2, outsend2}); else n_pass++;
        n_total++; if (done_count !== 16'd0) $display("FAIL spurious_done: got %0d want 0", done_count); else n_pass++;
        in_valid = 1'b1; in_data = 16'h5A5A;
        @(negedge clkCPU);
        in_valid = 1'b0;
        @(negedge clkCPU);
        n_total++; if ({outsend1, outsend2} !== 2'b10 || outdata1 !== 16'h5A5A) $display("FAIL spurious_rr: got %b %h want 10 5a5a", {outsend1, outsend2}, outdata1); else n_pass++;
        hs_manual(1);
        force dut.r_done_count = 16'hFFFF;
        @(posedge clkCPU);
        #1 release dut.r_done_count;
        @(negedge clkCPU);
        n_total++; if (done_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", done_count); else n_pass++;
        in_valid = 1'b1; in_data = 16'hC3C3;
        @(negedge clkCPU);
        in_valid = 1'b0;
        @(negedge clkCPU);
        n_total++; if ({outsend1, outsend2} !== 2'b01 || outdata2 !== 16'hC3C3) $display("FAIL wrap_ch2: got %b %h want 01 c3c3", {outsend1, outsend2}, outdata2); else n_pass++;
        hs_manual(2);
        n_total++; if (done_count !== 16'h0000) $display("FAIL wrap_done: got %h want 0000", done_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_fifo();
        test_async();
        test_spurious_wrap();
        n_total++;
        if (stab_fail1 + stab_fail2 != 0) $display("FAIL outdata_stable: got %0d changes while send high, want 0", stab_fail1 + stab_fail2);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
